// File: rtl/stack_exec_unit.sv
// stack_exec_unit
//   Small stack machine execution unit. Commands are offered on a
//   valid/ready handshake, executed over one (PUSH/POP/NOT/DUP) or two
//   (ADD/SUB/AND/SWAP) cycles, and signalled complete with a one-cycle
//   done pulse. Illegal commands (overflow/underflow) leave the stack
//   untouched and raise a sticky error that blocks further commands
//   until err_clr.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active low
//     cmd_valid  command offered
//     cmd_ready  unit can accept a command this cycle
//     cmd_op     opcode: PUSH POP ADD SUB AND NOT DUP SWAP (0..7)
//     cmd_imm    PUSH operand
//     flush      empty the stack (only honoured while idle)
//     err_clr    clear the sticky error
//     tos_out    top-of-stack value, 0 when empty
//     depth_out  number of entries on the stack
//     zero       tos_out == 0
//     done       one-cycle completion pulse
//     err        sticky error flag
//     err_code   00 none, 01 overflow, 10 underflow
module stack_exec_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_imm,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         tos_out,
  output logic [$clog2(DEPTH):0]   depth_out,
  output logic                     zero,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [WIDTH-1:0] wdata0, wdata1;

  logic [AW-1:0]    top_idx, nos_idx, push_idx;
  logic [WIDTH-1:0] tos_val;
  logic             accept, legal, needs_room, is_binary;

  // Index helpers; top/nos are only meaningful when the legality check
  // has confirmed enough entries are present.
  assign top_idx  = AW'(count_q - CNT_ONE);
  assign nos_idx  = AW'(count_q - CNT_TWO);
  assign push_idx = count_q[AW-1:0];
  assign tos_val  = (count_q == '0) ? '0 : mem[top_idx];

  // rst gates ready so it drops immediately on reset assertion.
  assign cmd_ready = rst & (state_q == IDLE) & ~err_q & ~flush;
  assign accept    = cmd_valid & cmd_ready;

  assign tos_out   = tos_val;
  assign zero      = (tos_val == '0);
  assign depth_out = count_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  // Legality of the latched opcode against the current fill level.
  always_comb begin
    needs_room = (op_q == OP_PUSH) || (op_q == OP_DUP);
    is_binary  = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                 (op_q == OP_AND) || (op_q == OP_SWAP);
    if (needs_room) begin
      legal = (count_q < CNT_FULL);
    end else if (is_binary) begin
      legal = (count_q >= CNT_TWO);
    end else begin
      legal = (count_q >= CNT_ONE);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: binary ops need a second cycle to write back.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC1;
      EXEC1:   state_d = (legal && is_binary) ? EXEC2 : IDLE;
      EXEC2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic. Stack writes are decoded from the state
  // register only, so nothing is written while reset holds IDLE.
  always_comb begin
    count_d    = count_q;
    op_d       = op_q;
    imm_d      = imm_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    we0        = 1'b0;
    waddr0     = '0;
    wdata0     = '0;
    we1        = 1'b0;
    waddr1     = '0;
    wdata1     = '0;

    // A newly detected error below takes precedence over a clear.
    if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          imm_d = cmd_imm;
        end else if (flush) begin
          count_d = '0;
        end
      end

      EXEC1: begin
        if (!legal) begin
          err_d      = 1'b1;
          err_code_d = needs_room ? ERR_OVF : ERR_UNF;
          done_d     = 1'b1;
        end else begin
          unique case (op_q)
            OP_PUSH: begin
              we0     = 1'b1;
              waddr0  = push_idx;
              wdata0  = imm_q;
              count_d = count_q + CNT_ONE;
              done_d  = 1'b1;
            end
            OP_POP: begin
              count_d = count_q - CNT_ONE;
              done_d  = 1'b1;
            end
            OP_NOT: begin
              we0    = 1'b1;
              waddr0 = top_idx;
              wdata0 = ~tos_val;
              done_d = 1'b1;
            end
            OP_DUP: begin
              we0     = 1'b1;
              waddr0  = push_idx;
              wdata0  = tos_val;
              count_d = count_q + CNT_ONE;
              done_d  = 1'b1;
            end
            default: begin
              opa_d = mem[nos_idx];
              opb_d = tos_val;
            end
          endcase
        end
      end

      EXEC2: begin
        done_d = 1'b1;
        unique case (op_q)
          OP_ADD: begin
            we0     = 1'b1;
            waddr0  = nos_idx;
            wdata0  = opa_q + opb_q;
            count_d = count_q - CNT_ONE;
          end
          OP_SUB: begin
            we0     = 1'b1;
            waddr0  = nos_idx;
            wdata0  = opa_q - opb_q;
            count_d = count_q - CNT_ONE;
          end
          OP_AND: begin
            we0     = 1'b1;
            waddr0  = nos_idx;
            wdata0  = opa_q & opb_q;
            count_d = count_q - CNT_ONE;
          end
          OP_SWAP: begin
            we0    = 1'b1;
            waddr0 = nos_idx;
            wdata0 = opb_q;
            we1    = 1'b1;
            waddr1 = top_idx;
            wdata1 = opa_q;
          end
          default: begin
          end
        endcase
      end

      default: begin
      end
    endcase
  end

  // Control and operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      op_q       <= OP_PUSH;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      count_q    <= count_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Stack storage; contents are not reset, only the count is.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

endmodule

// File: doc/stack_exec_unit.md
STACK_EXEC_UNIT -- requirements
Module: stack_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 16, meaning stack entries, a power of two >=4; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  unit can accept a command.
REQ-007 SHALL have port cmd_op  input  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 DUP, 111 SWAP.
REQ-008 SHALL have port cmd_imm  input  WIDTH  PUSH operand.
REQ-009 SHALL have port flush  input  1  synchronous stack empty request.
REQ-010 SHALL have port err_clr  input  1  clears sticky error.
REQ-011 SHALL have port tos_out  output  WIDTH  top-of-stack value, 0 when empty.
REQ-012 SHALL have port depth_out  output  AW+1  current entry count, 0..DEPTH.
REQ-013 SHALL have port zero  output  1  high when tos_out == 0.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  sticky error flag.
REQ-016 SHALL have port err_code  output  2  00 none, 01 overflow, 10 underflow.

Function
REQ-017 SHALL store entries in an internal DEPTH x WIDTH array with count register; no wrap-around, count saturates by error checking only.
REQ-018 SHALL implement FSM states IDLE, EXEC1, EXEC2; cmd_ready = (state==IDLE) & !err & !flush.
REQ-019 SHALL accept a command on a rising edge where cmd_valid & cmd_ready, latching cmd_op and cmd_imm, and moving IDLE->EXEC1.
REQ-020 SHALL, in EXEC1, check legality: PUSH/DUP need count<DEPTH (else overflow); POP/NOT need count>=1; ADD/SUB/AND/SWAP need count>=2 (else underflow).
REQ-021 SHALL, on illegal command, leave stack and count unchanged, set err=1, latch err_code, pulse done, return to IDLE at end of EXEC1.
REQ-022 SHALL complete PUSH, POP, NOT, DUP at end of EXEC1 (result visible after that edge), then return to IDLE.
REQ-023 SHALL, for ADD/SUB/AND/SWAP, read NOS and TOS into operand registers in EXEC1, write result in EXEC2, return to IDLE at end of EXEC2.
REQ-024 SHALL compute ADD=NOS+TOS, SUB=NOS-TOS, AND=NOS&TOS modulo 2^WIDTH, pop two and push result (count-1); SWAP exchanges NOS and TOS (count unchanged).
REQ-025 SHALL compute NOT as bitwise inversion of TOS in place; DUP pushes copy of TOS; POP discards TOS.
REQ-026 SHALL assert done for exactly one cycle following the completing edge; cmd_ready is high in that same cycle (when no error), giving a back-to-back rate of one command per 2 (unary) or 3 (binary) cycles.
REQ-027 SHALL keep err and err_code until an edge with err_clr=1; err_clr with no error has no effect; cmd_ready low while err=1.
REQ-028 SHALL, on flush in IDLE, set count to 0 at that edge; flush outside IDLE is ignored; flush and cmd_valid together: flush wins, command not accepted.
REQ-029 SHALL not assert done or change any output while IDLE with no accepted command.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, count=0, tos_out=0, depth_out=0, zero=1, done=0, err=0, err_code=00, cmd_ready=0; array contents need not clear.
REQ-031 SHALL discard any in-flight command on reset; cmd_ready rises in the first cycle after rst deasserts.

Verification (WIDTH=8, DEPTH=4)
REQ-032 SHALL cover: PUSH 5, PUSH 3, SUB -> tos_out=2, depth_out=1, done pulsed 3 times, err=0.
REQ-033 SHALL cover: PUSH 0x80, DUP, ADD -> tos_out=0x00, zero=1, depth_out=1.
REQ-034 SHALL cover: 4x PUSH then 5th PUSH 9 -> err=1, err_code=01, depth_out=4, tos_out unchanged, cmd_ready=0; err_clr -> err=0, cmd_ready=1.
REQ-035 SHALL cover: PUSH 7 then ADD -> err_code=10, depth_out=1, tos_out=7.
REQ-036 SHALL cover: PUSH 1, PUSH 2, SWAP -> tos_out=1; POP -> tos_out=2, depth_out=1; flush -> depth_out=0, tos_out=0.
REQ-037 SHALL cover: rst=0 asserted mid-EXEC2 of ADD -> outputs per REQ-030 immediately (before next clk edge), no done pulse.
